sub_chain: RTL and testbench
============================

# sub_chain

Parametrised elastic pipeline of `DEPTH` registered stages, each `WIDTH` bits wide, joined by valid/ready handshakes. It generalises the fixed two-instance, 8-bit `sub` chain into one block. It runs at full throughput, preserves order, applies backpressure, supports a synchronous flush, and reports occupancy. It sits between a producer and a consumer that need registered timing and slack.

## Interface
- `WIDTH`, 8: data width in bits; must be ≥1.
- `DEPTH`, 2: number of stages; must be ≥1 (elaboration error otherwise).
- `CNT_W`, `$clog2(2*DEPTH+1)`: occupancy width; derived, not overridden.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous clear of all stages.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  chain can accept a word.
- `in_data`  in  WIDTH  producer word.
- `out_valid`  out  1  chain presents a word.
- `out_ready`  in  1  consumer takes the word.
- `out_data`  out  WIDTH  oldest word held.
- `occupancy`  out  CNT_W  number of words held, 0..2*DEPTH.

## Operation
- Each stage holds a main register and a skid register. Its state is `ST_EMPTY`, `ST_ONE` or `ST_TWO`.
- Stage signals: push = up_valid & up_ready; pop = dn_valid & dn_ready. up_ready = (state != `ST_TWO`), so ready is a function of registered state only. dn_valid = (state != `ST_EMPTY`). dn_data = main.
- `ST_EMPTY`: push → `ST_ONE`, main←in.
- `ST_ONE`:
  - push&pop → `ST_ONE`, main←in.
  - push&!pop → `ST_TWO`, skid←in.
  - !push&pop → `ST_EMPTY`.
- `ST_TWO`: pop → `ST_ONE`, main←skid. Push is impossible in this state.
- Stage k's downstream connects to stage k+1's upstream. Stage 0 connects to `in_*`; stage DEPTH-1 connects to `out_*`.
- `occupancy` = sum of stage counts (EMPTY=0, ONE=1, TWO=2). It is combinational from registered state and is zero-extended to `CNT_W`.
- `flush`:
  - Priority over push/pop.
  - Next edge: every stage goes to `ST_EMPTY` and the data registers become 0.
  - While `flush`=1, `in_ready` and `out_valid` are forced 0, so no transfer happens that cycle.
- Data is never dropped, duplicated or reordered outside flush/reset.

## Timing
- Reset (async assert, sync release by the system): all stages `ST_EMPTY` and data registers 0.
  - Resulting outputs: `out_valid`=0, `out_data`=0, `in_ready`=1, `occupancy`=0.
  - Outputs take these values immediately on assertion, including mid-transfer.
- Latency into an empty chain: a word accepted at edge N appears on `out_valid` after edge N+DEPTH-1, i.e. it is visible DEPTH cycles after the cycle of acceptance.
- Throughput: 1 word/cycle sustained while `out_ready`=1.
- Capacity: 2*DEPTH words. With `out_ready` held 0 and `in_valid` held 1, exactly 2*DEPTH words are accepted, then `in_ready` falls to 0.
- `in_ready` recovers one cycle after the first downstream pop frees stage 0's skid.
- Simultaneous push and pop at a full chain: not possible at the input (in_ready=0). An internal pop and a refill in the same cycle are legal and keep the count constant.
- `in_valid`/`in_data` must remain stable until accepted. This is a producer obligation; the bench asserts it.

## Structure
- Package `sub_chain_pkg` holds:
  - `stage_state_e` (`ST_EMPTY`, `ST_ONE`, `ST_TWO`);
  - function `stage_count(stage_state_e)` returning a 2-bit count.
- Sub-module `chain_stage #(WIDTH)` contains one stage with up/down handshake ports, `flush`, and a 2-bit count output.
- `sub_chain` instantiates it `DEPTH` times in a generate loop and sums the counts.

## Test plan
1. Assert `rst_n`=0 mid-stream with words held → immediately `out_valid`=0, `out_data`=0, `in_ready`=1, `occupancy`=0. After release, no stale word appears.
2. DEPTH=2, `out_ready`=1, single word 8'hA5 accepted at cycle 0 → `out_valid`=1 with 8'hA5 in cycle 2 only; `occupancy`=1 in cycles 1–2, then 0.
3. Stream 8'h00..8'h0F back-to-back, `out_ready`=1 → `in_ready` never drops; outputs 8'h00..8'h0F in order on consecutive cycles starting at cycle 2.
4. `out_ready`=0, `in_valid`=1 with 8'h10,8'h11,… → exactly 4 accepted, `occupancy`=4, `in_ready`=0. Then `out_ready`=1 → 8'h10..8'h13 drained at 1/cycle, in order.
5. Three words held, `flush`=1 for one cycle with `in_valid`=1 → no handshake that cycle; next cycle `occupancy`=0, `out_valid`=0; flushed words never emerge.
6. DEPTH=4, WIDTH=32, random `in_valid`/`out_ready` for 10k cycles → scoreboard matches in order; `occupancy` equals the scoreboard count every cycle and never exceeds 8.

Source files
------------

// File: rtl/sub_chain_pkg.sv
// Shared types for the sub_chain elastic pipeline: per-stage state and the
// helper that turns a stage state into the number of words it holds.
package sub_chain_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  function automatic logic [1:0] stage_count(input stage_state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/chain_stage.sv
// One elastic stage: main register plus skid register, so up_ready depends
// only on registered state and the stage still sustains one word per cycle.
//
// state    | meaning
// ST_EMPTY | no word held
// ST_ONE   | one word in r_main
// ST_TWO   | r_main holds the oldest word, r_skid the next one
module chain_stage
  import sub_chain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_up_valid,
  output logic             o_up_ready,
  input  logic [WIDTH-1:0] i_up_data,
  output logic             o_dn_valid,
  input  logic             i_dn_ready,
  output logic [WIDTH-1:0] o_dn_data,
  output logic [1:0]       o_count
);

  stage_state_e     r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_push;
  logic             w_pop;

  // Flush masks both handshakes so nothing moves in the flush cycle.
  assign o_up_ready = (r_state != ST_TWO) && !i_flush;
  assign o_dn_valid = (r_state != ST_EMPTY) && !i_flush;
  assign o_dn_data  = r_main;
  assign o_count    = stage_count(r_state);

  assign w_push = i_up_valid && o_up_ready;
  assign w_pop  = o_dn_valid && i_dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (i_flush) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_state <= ST_ONE;
            r_main  <= i_up_data;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            r_main <= i_up_data;
          end else if (w_push) begin
            r_state <= ST_TWO;
            r_skid  <= i_up_data;
          end else if (w_pop) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            r_state <= ST_ONE;
            r_main  <= r_skid;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/sub_chain.sv
// DEPTH elastic stages in series with flush and occupancy reporting; each
// stage adds one cycle of latency and two words of slack.
module sub_chain
  import sub_chain_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("sub_chain: DEPTH must be at least 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("sub_chain: WIDTH must be at least 1");
  end

  // Link k is the upstream side of stage k; link DEPTH is the chain output.
  logic             w_valid [0:DEPTH];
  logic             w_ready [0:DEPTH];
  logic [WIDTH-1:0] w_data  [0:DEPTH];
  logic [1:0]       w_cnt   [0:DEPTH-1];
  logic [CNT_W-1:0] w_occ;

  assign w_valid[0]     = in_valid;
  assign w_data[0]      = in_data;
  assign in_ready       = w_ready[0];
  assign out_valid      = w_valid[DEPTH];
  assign out_data       = w_data[DEPTH];
  assign w_ready[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    chain_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_flush    (flush),
      .i_up_valid (w_valid[k]),
      .o_up_ready (w_ready[k]),
      .i_up_data  (w_data[k]),
      .o_dn_valid (w_valid[k+1]),
      .i_dn_ready (w_ready[k+1]),
      .o_dn_data  (w_data[k+1]),
      .o_count    (w_cnt[k])
    );
  end

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occ = w_occ + CNT_W'(w_cnt[k]);
    end
  end

  assign occupancy = w_occ;

endmodule

// File: tb/tb_sub_chain.sv
// Bench for sub_chain: directed cases on an 8-bit/2-stage chain, random
// traffic on a 32-bit/4-stage chain, both scored against word queues.
module tb_sub_chain;

  logic clk;
  logic rst_n;

  logic       a_flush, a_iv, a_ir, a_ov, a_or;
  logic [7:0] a_id, a_od;
  logic [2:0] a_occ;

  logic        b_flush, b_iv, b_ir, b_ov, b_or;
  logic [31:0] b_id, b_od;
  logic [3:0]  b_occ;

  int errors = 0;
  int checks = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  sub_chain #(.WIDTH(8), .DEPTH(2)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .occupancy(a_occ)
  );

  sub_chain #(.WIDTH(32), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .occupancy(b_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Input side: record every accepted word half a cycle after it was offered.
  logic        b_pend;
  logic [31:0] b_pdata;
  initial begin
    b_pend  = 1'b0;
    b_pdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n || a_flush) qa.delete();
      else if (a_iv && a_ir) qa.push_back(32'(a_id));
      if (!rst_n || b_flush) begin
        qb.delete();
      end else begin
        if (b_pend) chk("stable_b", {b_iv, b_id}, {1'b1, b_pdata});
        if (b_iv && b_ir) qb.push_back(b_id);
      end
      b_pend  = rst_n && !b_flush && b_iv && !b_ir;
      b_pdata = b_id;
    end
  end

  // Output side: pop and compare each delivered word, and track occupancy.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n) begin
      chk("occ_a", 32'(a_occ), qa.size());
      if (a_ov && a_or) begin
        if (qa.size() == 0) chk("unexpected_a", 32'(a_ov), 32'd0);
        else begin
          e = qa.pop_front();
          chk("data_a", 32'(a_od), e);
        end
      end
      chk("occ_b", 32'(b_occ), qb.size());
      chk("occ_max_b", 32'(b_occ > 4'd8), 32'd0);
      if (b_ov && b_or) begin
        if (qb.size() == 0) chk("unexpected_b", 32'(b_ov), 32'd0);
        else begin
          e = qb.pop_front();
          chk("data_b", b_od, e);
        end
      end
    end
  end

  initial begin
    int  n;
    logic acc;
    logic hold;
    rst_n = 1'b0;
    a_flush = 0; a_iv = 0; a_id = '0; a_or = 1;
    b_flush = 0; b_iv = 0; b_id = '0; b_or = 1;
    #2;
    chk("rst_ov_a", 32'(a_ov), 0);  chk("rst_od_a", 32'(a_od), 0);
    chk("rst_ir_a", 32'(a_ir), 1);  chk("rst_occ_a", 32'(a_occ), 0);
    chk("rst_ov_b", 32'(b_ov), 0);  chk("rst_ir_b", 32'(b_ir), 1);
    @(posedge clk); #3; rst_n = 1'b1;
    step(); step();

    // single word latency
    a_iv = 1; a_id = 8'hA5;
    chk("lat_c0_ready", 32'(a_ir), 1);
    step(); a_iv = 0;
    chk("lat_c1_valid", 32'(a_ov), 0); chk("lat_c1_occ", 32'(a_occ), 1);
    step();
    chk("lat_c2_valid", 32'(a_ov), 1); chk("lat_c2_data", 32'(a_od), 32'hA5);
    chk("lat_c2_occ", 32'(a_occ), 1);
    step();
    chk("lat_c3_valid", 32'(a_ov), 0); chk("lat_c3_occ", 32'(a_occ), 0);
    step();

    // back-to-back stream
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin a_iv = 1; a_id = 8'(c); end
      else a_iv = 0;
      if (c < 16) chk("stream_ready", 32'(a_ir), 1);
      if (c >= 2) begin
        chk("stream_valid", 32'(a_ov), 1);
        chk("stream_data", 32'(a_od), 32'(c - 2));
      end
      step();
    end
    step(); step();

    // fill to capacity with the consumer stalled
    a_or = 0; a_iv = 1; a_id = 8'h10; n = 0;
    for (int c = 0; c < 8; c++) begin
      acc = a_ir;
      step();
      if (acc) begin n++; a_id = 8'(8'h10 + n); end
    end
    chk("cap_count", 32'(n), 4);
    chk("cap_occ", 32'(a_occ), 4);
    chk("cap_ready", 32'(a_ir), 0);
    a_or = 1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", 32'(a_ov), 1);
      chk("drain_data", 32'(a_od), 32'(8'h10 + k));
      acc = a_iv && a_ir;
      step();
      if (acc) a_iv = 0;
    end
    for (int c = 0; c < 8 && a_iv; c++) begin
      acc = a_ir;
      step();
      if (acc) a_iv = 0;
    end
    repeat (5) step();

    // flush with three words held and a word offered
    a_or = 0; a_iv = 1;
    for (int c = 0; c < 3; c++) begin a_id = 8'(8'h20 + c); step(); end
    a_id = 8'h23; a_flush = 1;
    #1;
    chk("flush_ready", 32'(a_ir), 0); chk("flush_valid", 32'(a_ov), 0);
    step();
    a_flush = 0; a_iv = 0;
    chk("post_flush_occ", 32'(a_occ), 0); chk("post_flush_valid", 32'(a_ov), 0);
    a_or = 1;
    repeat (5) step();

    // asynchronous reset with words held in both chains
    a_or = 0; b_or = 0; a_iv = 1; b_iv = 1;
    for (int c = 0; c < 3; c++) begin a_id = 8'(8'h30 + c); b_id = 32'hC0DE_0000 + c; step(); end
    #2; rst_n = 1'b0; a_iv = 0; b_iv = 0;
    #1;
    chk("mid_rst_ov_a", 32'(a_ov), 0);  chk("mid_rst_od_a", 32'(a_od), 0);
    chk("mid_rst_ir_a", 32'(a_ir), 1);  chk("mid_rst_occ_a", 32'(a_occ), 0);
    chk("mid_rst_ov_b", 32'(b_ov), 0);  chk("mid_rst_od_b", b_od, 0);
    chk("mid_rst_ir_b", 32'(b_ir), 1);  chk("mid_rst_occ_b", 32'(b_occ), 0);
    step(); step();
    #2; rst_n = 1'b1;
    a_or = 1; b_or = 1;
    repeat (6) step();

    // random traffic on the deep chain
    hold = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      b_or    = ($urandom_range(0, 3) != 0) || (c[9:8] == 2'b01 ? 1'b0 : 1'b0);
      if (c[10:9] == 2'b11) b_or = ($urandom_range(0, 3) == 0);
      b_flush = ($urandom_range(0, 499) == 0);
      if (!hold) begin
        b_iv = ($urandom_range(0, 2) != 0);
        b_id = $urandom;
      end
      #1;
      hold = b_iv && !b_ir && !b_flush;
      step();
    end
    b_flush = 0;
    b_or = 1;
    while (hold) begin
      #1; hold = b_iv && !b_ir;
      step();
    end
    b_iv = 0;
    repeat (12) step();
    chk("final_empty_a", qa.size(), 0);
    chk("final_empty_b", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
